c2_bus_master: RTL and testbench

Cache-side master for the C2 line bus: accepts one line fill or line writeback request at a time from the cache controller, runs the C2 command/response handshake, and serializes or deserializes the 128-bit line over the 16-bit shared data bus in 8 beats. Sits between the cache controller (upstream) and the memory model on the C2 bus (downstream). It is the only C2 master.

---
 rtl/c2_pkg.sv | 24 ++
 rtl/c2_bus_master.sv | 128 ++++++++++++
 tb/tb_c2_bus_master.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/c2_pkg.sv
// Shared C2 line-bus definitions: command encodings, bus geometry, master states.
// Imported by the bus master and by the memory model on the other side of the bus.
package c2_pkg;
   localparam int C2_ADDR_W     = 15;
   localparam int C2_BUS_W      = 16;
   localparam int C2_LINE_BYTES = 16;
   localparam int C2_BEATS      = C2_LINE_BYTES * 8 / C2_BUS_W;
   localparam int C2_TIMEOUT    = 64;

   typedef enum logic [1:0] {
      C2_NOP      = 2'd0,
      C2_RESPONSE = 2'd1,
      C2_READ     = 2'd2,
      C2_WRITE    = 2'd3
   } c2_cmd_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_XFER  = 3'd3,
      ST_TURN  = 3'd4
   } c2_state_e;
endpackage

// File: rtl/c2_bus_master.sv
// C2 bus master: one line fill or writeback at a time, 128-bit line moved as
// 8 x 16-bit beats over the shared bus, with a response watchdog.
module c2_bus_master
   import c2_pkg::*;
#(
   parameter int ADDR_W     = C2_ADDR_W,
   parameter int BUS_W      = C2_BUS_W,
   parameter int LINE_BYTES = C2_LINE_BYTES,
   parameter int TIMEOUT    = C2_TIMEOUT
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_write,
   input  logic [ADDR_W-1:0]       req_addr,
   input  logic [LINE_BYTES*8-1:0] req_wdata,
   output logic                    resp_valid,
   output logic [LINE_BYTES*8-1:0] resp_rdata,
   output logic                    err,
   output logic [ADDR_W-1:0]       mem_addr,
   inout  wire  [BUS_W-1:0]        mem_data,
   inout  wire  [1:0]              mem_command
);
   localparam int LINE_W = LINE_BYTES * 8;
   localparam int BEATS  = LINE_W / BUS_W;
   localparam int BEAT_W = $clog2(BEATS);
   localparam int WD_W   = $clog2(TIMEOUT + 1);

   c2_state_e           r_state, w_next;
   logic                r_write;
   logic [ADDR_W-1:0]   r_addr;
   logic [LINE_W-1:0]   r_wdata;
   logic [LINE_W-1:0]   r_buf;
   logic [LINE_W-1:0]   r_rdata;
   logic [BEAT_W-1:0]   r_beat;
   logic [WD_W-1:0]     r_wd;
   logic                r_resp_valid;
   logic                r_err;

   logic                w_rsp;
   logic                w_last;
   logic                w_timeout;
   logic                w_drop;
   logic                w_cmd_oe;
   logic [1:0]          w_cmd;
   logic                w_data_oe;
   logic [BUS_W-1:0]    w_wbeat;

   assign w_rsp     = (mem_command == C2_RESPONSE);
   assign w_last    = (r_state == ST_XFER) && w_rsp && (r_beat == BEAT_W'(BEATS - 1));
   assign w_timeout = (r_state == ST_WAIT) && !w_rsp && (r_wd == WD_W'(TIMEOUT - 1));
   assign w_drop    = (r_state == ST_XFER) && !w_rsp;
   assign w_wbeat   = r_wdata[int'(r_beat) * BUS_W +: BUS_W];

   always_comb begin
      w_next    = r_state;
      w_cmd_oe  = 1'b0;
      w_cmd     = C2_NOP;
      w_data_oe = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_cmd_oe = 1'b1;
            if (req_valid) w_next = ST_ISSUE;
         end
         ST_ISSUE: begin
            w_cmd_oe  = 1'b1;
            w_cmd     = r_write ? C2_WRITE : C2_READ;
            w_data_oe = r_write;
            w_next    = ST_WAIT;
         end
         ST_WAIT: begin
            // beat 0 stays on the bus until the memory's first RESPONSE edge takes it
            w_data_oe = r_write;
            if (w_rsp)          w_next = ST_XFER;
            else if (w_timeout) w_next = ST_TURN;
         end
         ST_XFER: begin
            w_data_oe = r_write;
            if (w_drop || w_last) w_next = ST_TURN;
         end
         ST_TURN: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_write      <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_buf        <= '0;
         r_rdata      <= '0;
         r_beat       <= '0;
         r_wd         <= '0;
         r_resp_valid <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_state      <= w_next;
         r_resp_valid <= w_last;
         r_err        <= w_timeout || w_drop;
         if (r_state == ST_IDLE && req_valid) begin
            r_write <= req_write;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_beat  <= '0;
            r_wd    <= '0;
         end
         if (r_state == ST_WAIT && !w_rsp) r_wd <= r_wd + 1'b1;
         if ((r_state == ST_WAIT || r_state == ST_XFER) && w_rsp) begin
            if (!r_write) r_buf[int'(r_beat) * BUS_W +: BUS_W] <= mem_data;
            if (!w_last) r_beat <= r_beat + 1'b1;
         end
         // fill data is published only when the whole line arrived, so a dropped
         // transfer leaves the previous line visible
         if (w_last && !r_write) r_rdata <= {mem_data, r_buf[LINE_W-BUS_W-1:0]};
      end
   end

   assign req_ready   = (r_state == ST_IDLE) && !reset;
   assign resp_valid  = r_resp_valid;
   assign resp_rdata  = r_rdata;
   assign err         = r_err;
   assign mem_addr    = r_addr;
   assign mem_command = w_cmd_oe  ? w_cmd   : 2'bzz;
   assign mem_data    = w_data_oe ? w_wbeat : {BUS_W{1'bz}};
endmodule

// File: tb/tb_c2_bus_master.sv
// Bench for c2_bus_master: behavioural C2 memory responder on the bus plus a
// line-level reference of memory contents and the expected fill data.
module tb_c2_bus_master;
   import c2_pkg::*;

   localparam logic [127:0] LINE_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
   localparam logic [127:0] LINE_W = 128'h0F0E0D0C_0B0A0908_07060504_03020100;

   logic          clk;
   logic          reset;
   logic          req_valid;
   logic          req_ready;
   logic          req_write;
   logic [14:0]   req_addr;
   logic [127:0]  req_wdata;
   logic          resp_valid;
   logic [127:0]  resp_rdata;
   logic          err;
   logic [14:0]   mem_addr;
   wire  [15:0]   mem_data;
   wire  [1:0]    mem_command;

   int n_tests = 0;
   int n_fail  = 0;

   c2_bus_master dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .err        (err),
      .mem_addr   (mem_addr),
      .mem_data   (mem_data),
      .mem_command(mem_command)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // memory responder: registered RESPONSE one cycle after seeing READ/WRITE,
   // m_limit beats then silence; m_silent suppresses any response
   logic [127:0] m_mem [0:32767];
   logic         m_act;
   logic         m_wr;
   logic [14:0]  m_addr;
   logic [127:0] m_line;
   int           m_beat;
   int           m_limit = 8;
   bit           m_silent = 1'b0;

   always @(posedge clk) begin
      if (reset) begin
         m_act  <= 1'b0;
         m_beat <= 0;
         m_mem[15'h1234] <= LINE_A;
      end else if (!m_act) begin
         if (!m_silent && (mem_command == 2'd2 || mem_command == 2'd3)) begin
            m_act  <= 1'b1;
            m_wr   <= (mem_command == 2'd3);
            m_addr <= mem_addr;
            m_line <= m_mem[mem_addr];
            m_beat <= 0;
         end
      end else begin
         if (m_wr) m_line[m_beat*16 +: 16] <= mem_data;
         if (m_wr && m_beat == 7) m_mem[m_addr] <= {mem_data, m_line[111:0]};
         if (m_beat == m_limit - 1) m_act <= 1'b0;
         m_beat <= m_beat + 1;
      end
   end

   assign mem_command = m_act ? 2'd1 : 2'bzz;
   assign mem_data    = (m_act && !m_wr) ? m_line[m_beat*16 +: 16] : 16'hzzzz;

   // reference: line contents as the cache would see them, and the held fill line
   logic [127:0] ref_mem [int];
   logic [14:0]  known [$];
   logic [127:0] exp_rdata;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic txn(input bit wr, input logic [14:0] a, input logic [127:0] wd);
      bit bad;
      bad = 1'b0;
      req_write = wr; req_addr = a; req_wdata = wd; req_valid = 1'b1;
      chk("acc_ready", 128'(req_ready), 128'd1);
      tick();
      req_valid = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         tick();
         if (k == 1) chk("mem_addr", 128'(mem_addr), 128'(a));
         if (wr && k <= 8) chk("wbeat", 128'(mem_data), 128'(wd[(k-1)*16 +: 16]));
         if (k < 9 && (resp_valid || err)) bad = 1'b1;
      end
      chk("early_resp", 128'(bad), 128'd0);
      chk("resp_valid", 128'(resp_valid), 128'd1);
      chk("resp_err", 128'(err), 128'd0);
      chk("turn_ready", 128'(req_ready), 128'd0);
      if (wr) begin
         ref_mem[int'(a)] = wd;
         known.push_back(a);
      end else begin
         exp_rdata = ref_mem[int'(a)];
      end
      chk("rdata", resp_rdata, exp_rdata);
      tick();
      chk("idle_ready", 128'(req_ready), 128'd1);
      chk("resp_pulse", 128'(resp_valid), 128'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit bad;
      logic [14:0] a;
      reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
      ref_mem[32'h1234] = LINE_A;
      known.push_back(15'h1234);
      exp_rdata = '0;
      tick(); tick(); tick();
      chk("rst_ready", 128'(req_ready), 128'd0);
      chk("rst_resp", 128'(resp_valid), 128'd0);
      chk("rst_err", 128'(err), 128'd0);
      chk("rst_rdata", resp_rdata, 128'd0);
      chk("rst_addr", 128'(mem_addr), 128'd0);
      chk("rst_cmd", 128'(mem_command), 128'd0);
      reset = 1'b0;
      tick();
      chk("idle_ready0", 128'(req_ready), 128'd1);

      // directed fill of a preloaded line
      txn(1'b0, 15'h1234, '0);
      chk("beat0", 128'(resp_rdata[15:0]), 128'h0EEFF);

      // writeback then immediate read of the same line
      txn(1'b1, 15'h0007, LINE_W);
      txn(1'b0, 15'h0007, '0);
      chk("mem_line7", m_mem[7], LINE_W);
      chk("idle_nop", 128'(mem_command), 128'd0);

      // randomized mix against the reference line store
      for (int i = 0; i < 20; i++) begin
         if ($urandom_range(0, 1) == 1) begin
            a = 15'($urandom_range(0, 32767));
            if (a == 15'h1234) a = 15'h1235;
            txn(1'b1, a, {$urandom, $urandom, $urandom, $urandom});
         end else begin
            a = known[$urandom_range(0, known.size() - 1)];
            txn(1'b0, a, '0);
         end
      end

      // silent responder -> watchdog error
      m_silent = 1'b1;
      req_write = 1'b0; req_addr = 15'h0007; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      bad = 1'b0;
      for (int k = 1; k <= C2_TIMEOUT; k++) begin
         tick();
         if (err || resp_valid) bad = 1'b1;
      end
      chk("to_early", 128'(bad), 128'd0);
      tick();
      chk("to_err", 128'(err), 128'd1);
      chk("to_resp", 128'(resp_valid), 128'd0);
      chk("to_turn", 128'(req_ready), 128'd0);
      tick();
      chk("to_idle", 128'(req_ready), 128'd1);
      chk("to_errpulse", 128'(err), 128'd0);
      m_silent = 1'b0;

      // response dropped after beat 3 -> error, fill line unchanged
      m_limit = 4;
      req_write = 1'b0; req_addr = 15'h0007; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      bad = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         tick();
         if (err || resp_valid) bad = 1'b1;
      end
      chk("drop_early", 128'(bad), 128'd0);
      tick();
      chk("drop_err", 128'(err), 128'd1);
      chk("drop_resp", 128'(resp_valid), 128'd0);
      chk("drop_rdata", resp_rdata, exp_rdata);
      tick();
      chk("drop_idle", 128'(req_ready), 128'd1);
      m_limit = 8;

      // reset while beat 4 of a fill is on the bus
      req_write = 1'b0; req_addr = 15'h1234; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      for (int k = 1; k <= 5; k++) tick();
      reset = 1'b1;
      tick();
      chk("mrst_cmd", 128'(mem_command), 128'd0);
      chk("mrst_resp", 128'(resp_valid), 128'd0);
      chk("mrst_err", 128'(err), 128'd0);
      reset = 1'b0;
      exp_rdata = '0;
      bad = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (resp_valid || err || !req_ready) bad = 1'b1;
      end
      chk("mrst_quiet", 128'(bad), 128'd0);
      chk("mrst_rdata", resp_rdata, exp_rdata);
      txn(1'b0, 15'h1234, '0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
